// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store responder between the decode path and a
// word-addressed data memory with req/ack handshake and ack timeout.
module lsu_ctrl #(
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              memren_i,
   input  logic              memwren_i,
   input  logic [2:0]        funct3_i,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   output logic              resp_valid_o,
   output logic [DWIDTH-1:0] rdata_o,
   output logic              err_o,
   output logic              busy_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [DWIDTH-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DWIDTH-1:0] mem_rdata_i
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          f3_q, f3_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic [3:0]          be_q, be_d;
   logic [DWIDTH-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [DWIDTH-1:0]   rdata_q, rdata_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic                is_ld, is_st, f3_ok, mis, ok;
   logic [3:0]          be_in;
   logic [DWIDTH-1:0]   wd_in;
   logic [DWIDTH-1:0]   sh, ld_ext;

   // Request legality, byte enables and lane-replicated store data.
   always_comb begin
      is_ld = memren_i & ~memwren_i;
      is_st = memwren_i & ~memren_i;
      f3_ok = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b010: f3_ok = is_ld | is_st;
         3'b100, 3'b101:         f3_ok = is_ld;
         default:                f3_ok = 1'b0;
      endcase
      mis = ((funct3_i[1:0] == 2'b01) & addr_i[0])
          | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
      ok = f3_ok & ~mis;
      be_in = 4'b1111;
      wd_in = wdata_i;
      if (is_st) begin
         case (funct3_i[1:0])
            2'b00: begin
               be_in = 4'b0001 << addr_i[1:0];
               wd_in = {(DWIDTH/8){wdata_i[7:0]}};
            end
            2'b01: begin
               be_in = addr_i[1] ? 4'b1100 : 4'b0011;
               wd_in = {(DWIDTH/16){wdata_i[15:0]}};
            end
            default: begin
               be_in = 4'b1111;
               wd_in = wdata_i;
            end
         endcase
      end
   end

   // Align the returned word to the addressed lane and extend it.
   always_comb begin
      sh = mem_rdata_i >> {addr_q[1:0], 3'b000};
      case (f3_q)
         3'b000:  ld_ext = {{(DWIDTH-8){sh[7]}}, sh[7:0]};
         3'b001:  ld_ext = {{(DWIDTH-16){sh[15]}}, sh[15:0]};
         3'b100:  ld_ext = {{(DWIDTH-8){1'b0}}, sh[7:0]};
         3'b101:  ld_ext = {{(DWIDTH-16){1'b0}}, sh[15:0]};
         default: ld_ext = sh;
      endcase
   end

   // Next-state: accept, wait for ack or timeout, one-cycle response.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               we_d    = memwren_i;
               f3_d    = funct3_i;
               addr_d  = addr_i;
               be_d    = be_in;
               wdata_d = wd_in;
               err_d   = ~ok;
               rdata_d = '0;
               cnt_d   = '0;
               state_d = ok ? BUSY : RESP;
            end
         end
         BUSY: begin
            if (mem_ack_i) begin
               state_d = RESP;
               err_d   = 1'b0;
               if (!we_q) rdata_d = ld_ext;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are decoded from state so reset clears them at once.
   always_comb begin
      req_ready_o  = (state_q == IDLE);
      busy_o       = (state_q != IDLE);
      resp_valid_o = (state_q == RESP);
      err_o        = resp_valid_o & err_q;
      rdata_o      = resp_valid_o ? rdata_q : '0;
      mem_req_o    = (state_q == BUSY);
      mem_we_o     = mem_req_o & we_q;
      mem_addr_o   = mem_req_o ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
      mem_be_o     = mem_req_o ? be_q : 4'b0000;
      mem_wdata_o  = mem_req_o ? wdata_q : '0;
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: random and directed load/store traffic against a
// queue-based reference model with a separate response monitor.
module tb_lsu_ctrl;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        memren_i = 1'b0;
   logic        memwren_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        resp_valid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        busy_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   always #5 clk = ~clk;

   lsu_ctrl #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .memren_i(memren_i), .memwren_i(memwren_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .resp_valid_o(resp_valid_o), .rdata_o(rdata_o),
      .err_o(err_o), .busy_o(busy_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
      longint      t;
   } resp_t;

   typedef struct packed {
      int          delay;
      int          exp_len;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rdata;
   } plan_t;

   typedef struct packed {
      logic        legal;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
      int          lat;
   } model_t;

   resp_t rq[$];
   plan_t pq[$];
   int    nvec = 0;
   int    nerr = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic model_t model(input bit ren, input bit wen,
                                    input bit [2:0] f3,
                                    input bit [31:0] addr,
                                    input bit [31:0] wdata,
                                    input bit [31:0] mword,
                                    input int delay);
      model_t m;
      int size, off;
      bit lf3;
      logic [31:0] v, mask;
      size = 1 << f3[1:0];
      off  = int'(addr % 4);
      if (wen) lf3 = (f3 <= 3'd2);
      else     lf3 = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      m = '0;
      m.legal = (ren != wen) && lf3 && ((addr % size) == 0);
      if (!m.legal) begin
         m.err = 1'b1;
         m.rd  = '0;
         m.lat = 1;
         return m;
      end
      m.be = wen ? 4'(((1 << size) - 1) << off) : 4'hF;
      for (int i = 0; i < 4; i++)
         m.wd[8*i +: 8] = wdata[8*(i % size) +: 8];
      if (delay + 1 <= TO) begin
         m.err = 1'b0;
         m.lat = delay + 2;
         if (wen) begin
            m.rd = '0;
         end else begin
            v = mword >> (8 * off);
            mask = (size == 4) ? 32'hFFFF_FFFF
                               : 32'((64'd1 << (8 * size)) - 1);
            v = v & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            m.rd = v;
         end
      end else begin
         m.err = 1'b1;
         m.rd  = '0;
         m.lat = TO + 1;
      end
      return m;
   endfunction

   task automatic issue(input bit ren, input bit wen, input bit [2:0] f3,
                        input bit [31:0] addr, input bit [31:0] wdata,
                        input bit [31:0] mword, input int delay,
                        input bit want_resp, input int exp_len);
      model_t m;
      plan_t  p;
      resp_t  r;
      int     w;
      w = 0;
      @(negedge clk);
      while (!req_ready_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         nvec++;
         nerr++;
         $display("FAIL ready_wait: got ready=0 expected ready=1");
         return;
      end
      m = model(ren, wen, f3, addr, wdata, mword, delay);
      req_valid_i = 1'b1;
      memren_i    = ren;
      memwren_i   = wen;
      funct3_i    = f3;
      addr_i      = addr;
      wdata_i     = wdata;
      if (m.legal) begin
         p.delay   = delay;
         p.exp_len = exp_len;
         p.we      = wen;
         p.addr    = addr & ~32'd3;
         p.be      = m.be;
         p.wd      = m.wd;
         p.rdata   = mword;
         pq.push_back(p);
      end
      if (want_resp) begin
         r.rd  = m.rd;
         r.err = m.err;
         r.t   = longint'($time) + 10 * m.lat;
         rq.push_back(r);
      end
      @(negedge clk);
      req_valid_i = 1'b0;
      memren_i    = 1'($urandom);
      memwren_i   = 1'($urandom);
      funct3_i    = 3'($urandom);
      addr_i      = $urandom;
      wdata_i     = $urandom;
   endtask

   task automatic chk_hold(input plan_t p);
      chk("mem_hold",
          {32'd0, mem_req_o, busy_o, mem_we_o, mem_be_o},
          {32'd0, 1'b1, 1'b1, p.we, p.be});
      chk("mem_addr", {32'd0, mem_addr_o}, {32'd0, p.addr});
      if (p.we) chk("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, p.wd});
   endtask

   // Memory responder: acks after the planned delay and checks that
   // the request lines stay stable while waiting.
   initial begin : responder
      plan_t p;
      int    n;
      forever begin
         @(negedge clk);
         if (!mem_req_o) begin
            mem_ack_i   = ($urandom_range(0, 7) == 0);
            mem_rdata_i = $urandom;
         end else if (pq.size() == 0) begin
            mem_ack_i = 1'b0;
            nvec++;
            nerr++;
            $display("FAIL unexpected_mem_req: got req=1 expected req=0");
            while (mem_req_o) @(negedge clk);
         end else begin
            mem_ack_i = 1'b0;
            p = pq.pop_front();
            chk_hold(p);
            n = 1;
            forever begin
               if (n == p.delay + 1) begin
                  mem_ack_i   = 1'b1;
                  mem_rdata_i = p.rdata;
                  @(negedge clk);
                  mem_ack_i   = 1'b0;
                  mem_rdata_i = $urandom;
                  chk("req_drop_after_ack", {63'd0, mem_req_o}, 64'd0);
                  break;
               end
               @(negedge clk);
               if (!mem_req_o) begin
                  chk("req_cycles", 64'(n), 64'(p.exp_len));
                  break;
               end
               n++;
               chk_hold(p);
               if (n > 200) begin
                  chk("req_bound", 64'(n), 64'(p.exp_len));
                  break;
               end
            end
         end
      end
   end

   // Response monitor: pops the scoreboard on every completion pulse.
   initial begin : monitor
      resp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && resp_valid_o) begin
            if (rq.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_resp: got resp=1 expected none");
            end else begin
               e = rq.pop_front();
               chk("resp_err", {63'd0, err_o}, {63'd0, e.err});
               chk("resp_rdata", {32'd0, rdata_o}, {32'd0, e.rd});
               chk("resp_time", 64'($time), 64'(e.t));
            end
         end
      end
   end

   initial begin : stim
      bit        ren, wen;
      bit [2:0]  f3;
      bit [31:0] a;
      int        d, k, w;
      #3;
      chk("reset_outputs",
          {32'd0, req_ready_o, resp_valid_o, err_o, busy_o,
           mem_req_o, mem_we_o, mem_be_o},
          {32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      chk("reset_data",
          {rdata_o | mem_wdata_o, mem_addr_o}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, TO);
      issue(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 1, 1, TO);
      issue(1, 0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 1, TO);
      issue(1, 1, 3'b010, 32'h8, 32'h0, 32'h0, 0, 1, TO);
      issue(0, 0, 3'b000, 32'h8, 32'h0, 32'h0, 0, 1, TO);
      issue(0, 1, 3'b100, 32'h8, 32'h0, 32'h0, 0, 1, TO);
      issue(1, 0, 3'b101, 32'h2, 32'h0, 32'h8001_0000, 5, 1, TO);
      issue(0, 1, 3'b010, 32'h40, 32'h1234_5678, 32'h0, 1000, 1, TO);
      issue(0, 1, 3'b010, 32'h44, 32'h9ABC_DEF0, 32'h0, TO - 1, 1, TO);
      issue(0, 1, 3'b000, 32'h13, 32'h0000_00A5, 32'h0, 2, 1, TO);
      issue(1, 0, 3'b100, 32'h11, 32'h0, 32'h0000_F700, 0, 1, TO);

      // Reset in the middle of a pending load.
      issue(1, 0, 3'b010, 32'h80, 32'h0, 32'h0, 1000, 0, 4);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async",
          {32'd0, mem_req_o, resp_valid_o, busy_o, req_ready_o},
          {32'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(1, 0, 3'b010, 32'h84, 32'h0, 32'hCAFE_F00D, 0, 1, TO);

      for (int i = 0; i < 150; i++) begin
         k = $urandom_range(0, 9);
         ren = (k < 5) || (k == 9);
         wen = (k >= 5);
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom)
              : 3'(($urandom_range(0, 4) > 2) ? $urandom_range(4, 5)
                                               : $urandom_range(0, 2));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         k = $urandom_range(0, 19);
         d = (k == 0) ? TO : (k == 1) ? TO - 1 : (k == 2) ? 40
           : $urandom_range(0, 3);
         issue(ren, wen, f3, a, $urandom, $urandom, d, 1, TO);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      w = 0;
      while ((rq.size() != 0 || busy_o) && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("resp_drain", 64'(rq.size()), 64'd0);
      chk("plan_drain", 64'(pq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
